saxi_full_s00_axi: RTL and testbench



---
 rtl/saxi_pkg.sv | 32 +++
 rtl/axi_burst_addr.sv | 42 ++++
 rtl/saxi_full_s00_axi.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_saxi_full_s00_axi.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saxi_pkg.sv
// ---------------------------------------------------------------------------
// saxi_pkg
// Shared definitions for the AXI4-full slave memory model:
//   - AXI burst type and response encodings
//   - write / read channel FSM state types
//   - addr_lsb(): byte-offset bits within one data word
// ---------------------------------------------------------------------------
package saxi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Number of byte-offset bits inside one data word (log2 of byte lanes).
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// ---------------------------------------------------------------------------
// axi_burst_addr
// Combinational next-beat address for one AXI burst.
// Ports:
//   cur_addr  in   byte address of the current beat
//   len       in   AxLEN (beats - 1), sets the WRAP block size
//   burst     in   AxBURST
//   next_addr out  byte address of the following beat
// FIXED keeps the address, WRAP steps one word and folds back inside the
// aligned (len+1)*bytes block, INCR and the reserved code step one word.
// ---------------------------------------------------------------------------
module axi_burst_addr
    import saxi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = addr_lsb(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        incr_addr = cur_addr + ADDR_WIDTH'(BYTES);
        // Wrap block is (len+1) words; legal WRAP lengths make this a power of two.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LSB) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = cur_addr;
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            BURST_INCR:  next_addr = incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/saxi_full_s00_axi.sv
// ---------------------------------------------------------------------------
// saxi_full_s00_axi
// AXI4-full slave memory model backed by a word-addressed internal array.
// Write and read channels are independent FSMs and can run concurrently.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN       clock, synchronous active-low reset
//   S_AXI_AW*                        write address command (LOCK/CACHE/PROT/
//                                    QOS/REGION/USER/SIZE ignored)
//   S_AXI_W*                         write data (WLAST/WUSER ignored)
//   S_AXI_B*                         write response, always OKAY
//   S_AXI_AR*                        read address command (same ignored set)
//   S_AXI_R*                         read data, always OKAY
// Handshakes: a transfer happens on a rising clock edge where VALID and
// READY are both 1. This slave never makes its READY depend on VALID beyond
// the FSM state, and once its own VALID (B/R) is raised the payload is held
// unchanged until the matching READY completes the transfer.
// Memory contents are not reset; a reset in the middle of a write burst only
// abandons the remaining beats.
// ---------------------------------------------------------------------------
module saxi_full_s00_axi
    import saxi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH     = 1,
    parameter int C_S_AXI_DATA_WIDTH   = 128,
    parameter int C_S_AXI_ADDR_WIDTH   = 32,
    parameter int C_S_AXI_AWUSER_WIDTH = 0,
    parameter int C_S_AXI_ARUSER_WIDTH = 0,
    parameter int C_S_AXI_WUSER_WIDTH  = 0,
    parameter int C_S_AXI_RUSER_WIDTH  = 0,
    parameter int C_S_AXI_BUSER_WIDTH  = 0,
    parameter int MEM_ADDR_BITS        = 20
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    // write address
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic [3:0]                      S_AXI_AWREGION,
    input  logic [((C_S_AXI_AWUSER_WIDTH > 0) ? C_S_AXI_AWUSER_WIDTH : 1)-1:0] S_AXI_AWUSER,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // write data
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic [((C_S_AXI_WUSER_WIDTH > 0) ? C_S_AXI_WUSER_WIDTH : 1)-1:0] S_AXI_WUSER,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // write response
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic [((C_S_AXI_BUSER_WIDTH > 0) ? C_S_AXI_BUSER_WIDTH : 1)-1:0] S_AXI_BUSER,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // read address
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic [3:0]                      S_AXI_ARREGION,
    input  logic [((C_S_AXI_ARUSER_WIDTH > 0) ? C_S_AXI_ARUSER_WIDTH : 1)-1:0] S_AXI_ARUSER,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // read data
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic [((C_S_AXI_RUSER_WIDTH > 0) ? C_S_AXI_RUSER_WIDTH : 1)-1:0] S_AXI_RUSER,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int ADDR_LSB  = addr_lsb(C_S_AXI_DATA_WIDTH);
    localparam int STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // Low for the first cycle after reset so every READY reads 0 while the
    // reset is being applied and on the edge that releases it.
    logic out_of_reset;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t                      w_state;
    w_state_t                      w_state_nxt;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_addr_nxt;
    logic [7:0]                    w_len;
    logic [7:0]                    w_cnt;
    logic [1:0]                    w_burst;
    logic [C_S_AXI_ID_WIDTH-1:0]   w_id;
    logic [MEM_ADDR_BITS-1:0]      w_word;
    logic                          aw_hs;
    logic                          w_beat;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    // Gated by reset so a beat presented on the reset edge is dropped.
    assign w_beat = S_AXI_ARESETN && (w_state == W_DATA) && S_AXI_WVALID;
    assign w_word = w_addr[ADDR_LSB +: MEM_ADDR_BITS];

    axi_burst_addr #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
    ) u_w_addr (
        .cur_addr  (w_addr),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_addr_nxt)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = out_of_reset;
                if (S_AXI_AWVALID && out_of_reset) begin
                    w_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                // Beat count alone ends the burst; WLAST is not trusted.
                if (S_AXI_WVALID && (w_cnt == w_len)) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_INCR;
            w_id    <= '0;
        end else if (aw_hs) begin
            w_addr  <= S_AXI_AWADDR;
            w_len   <= S_AXI_AWLEN;
            w_cnt   <= '0;
            w_burst <= S_AXI_AWBURST;
            w_id    <= S_AXI_AWID;
        end else if (w_beat) begin
            w_addr  <= w_addr_nxt;
            w_cnt   <= w_cnt + 8'd1;
        end
    end

    // Byte-lane write; no reset so contents survive a channel reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_beat) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (S_AXI_WSTRB[i]) begin
                    mem[w_word][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
                end
            end
        end
    end

    assign S_AXI_BID   = w_id;
    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_BUSER = '0;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t                      r_state;
    r_state_t                      r_state_nxt;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr_nxt;
    logic [7:0]                    r_len;
    logic [7:0]                    r_cnt;
    logic [1:0]                    r_burst;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_id;
    logic [MEM_ADDR_BITS-1:0]      r_word;
    logic                          ar_hs;
    logic                          r_beat;

    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_beat = S_AXI_RVALID && S_AXI_RREADY;
    assign r_word = r_addr[ADDR_LSB +: MEM_ADDR_BITS];

    axi_burst_addr #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
    ) u_r_addr (
        .cur_addr  (r_addr),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_addr_nxt)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt   = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RLAST   = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = out_of_reset;
                if (S_AXI_ARVALID && out_of_reset) begin
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                S_AXI_RLAST  = (r_cnt == r_len);
                if (S_AXI_RREADY && (r_cnt == r_len)) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= BURST_INCR;
            r_id    <= '0;
        end else if (ar_hs) begin
            r_addr  <= S_AXI_ARADDR;
            r_len   <= S_AXI_ARLEN;
            r_cnt   <= '0;
            r_burst <= S_AXI_ARBURST;
            r_id    <= S_AXI_ARID;
        end else if (r_beat) begin
            r_addr  <= r_addr_nxt;
            r_cnt   <= r_cnt + 8'd1;
        end
    end

    // Asynchronous array read: a write to the same word on this edge is not
    // yet visible, so the beat returns the old contents.
    assign S_AXI_RDATA = mem[r_word];
    assign S_AXI_RID   = r_id;
    assign S_AXI_RRESP = RESP_OKAY;
    assign S_AXI_RUSER = '0;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    // Command fields this memory model has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                             S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WLAST,
                             S_AXI_WUSER, S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE,
                             S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER};

endmodule

// File: tb/tb_saxi_full_s00_axi.sv
// ---------------------------------------------------------------------------
// tb_saxi_full_s00_axi
// Directed and randomized bursts against saxi_full_s00_axi. Expected read
// data comes from a word-indexed associative array updated per write beat,
// with beat addresses computed from the burst rules directly.
// ---------------------------------------------------------------------------
module tb_saxi_full_s00_axi;

    localparam int DW    = 128;
    localparam int NB    = DW / 8;
    localparam int IW    = 1;
    localparam int MAB   = 10;
    localparam int DEPTH = 1 << MAB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [IW-1:0] awid;    logic [31:0] awaddr;  logic [7:0] awlen;
    logic [2:0]    awsize;  logic [1:0]  awburst; logic       awvalid;
    logic          awready;
    logic [DW-1:0] wdata;   logic [NB-1:0] wstrb; logic wlast, wvalid, wready;
    logic [IW-1:0] bid;     logic [1:0]  bresp;   logic [0:0] buser;
    logic          bvalid,  bready;
    logic [IW-1:0] arid;    logic [31:0] araddr;  logic [7:0] arlen;
    logic [2:0]    arsize;  logic [1:0]  arburst; logic       arvalid;
    logic          arready;
    logic [IW-1:0] rid;     logic [DW-1:0] rdata; logic [1:0] rresp;
    logic          rlast;   logic [0:0]  ruser;   logic rvalid, rready;

    saxi_full_s00_axi #(
        .C_S_AXI_ID_WIDTH   (IW),
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (32),
        .MEM_ADDR_BITS      (MAB)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (aresetn),
        .S_AXI_AWID     (awid),
        .S_AXI_AWADDR   (awaddr),
        .S_AXI_AWLEN    (awlen),
        .S_AXI_AWSIZE   (awsize),
        .S_AXI_AWBURST  (awburst),
        .S_AXI_AWLOCK   (1'b0),
        .S_AXI_AWCACHE  (4'd0),
        .S_AXI_AWPROT   (3'd0),
        .S_AXI_AWQOS    (4'd0),
        .S_AXI_AWREGION (4'd0),
        .S_AXI_AWUSER   (1'b0),
        .S_AXI_AWVALID  (awvalid),
        .S_AXI_AWREADY  (awready),
        .S_AXI_WDATA    (wdata),
        .S_AXI_WSTRB    (wstrb),
        .S_AXI_WLAST    (wlast),
        .S_AXI_WUSER    (1'b0),
        .S_AXI_WVALID   (wvalid),
        .S_AXI_WREADY   (wready),
        .S_AXI_BID      (bid),
        .S_AXI_BRESP    (bresp),
        .S_AXI_BUSER    (buser),
        .S_AXI_BVALID   (bvalid),
        .S_AXI_BREADY   (bready),
        .S_AXI_ARID     (arid),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARLEN    (arlen),
        .S_AXI_ARSIZE   (arsize),
        .S_AXI_ARBURST  (arburst),
        .S_AXI_ARLOCK   (1'b0),
        .S_AXI_ARCACHE  (4'd0),
        .S_AXI_ARPROT   (3'd0),
        .S_AXI_ARQOS    (4'd0),
        .S_AXI_ARREGION (4'd0),
        .S_AXI_ARUSER   (1'b0),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RID      (rid),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RLAST    (rlast),
        .S_AXI_RUSER    (ruser),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_assert = 0;
    int n_fail   = 0;
    logic [DW-1:0] model [int];
    logic [DW-1:0] wr_data_q [$];
    logic [NB-1:0] wr_strb_q [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input logic [1:0] burst, input int k);
        logic [31:0] blk;
        logic [31:0] base;
        blk  = 32'((len + 1) * NB);
        base = a - (a % blk);
        case (burst)
            2'b00:   return a;
            2'b10:   return base + (((a - base) + 32'(k * NB)) % blk);
            default: return a + 32'(k * NB);
        endcase
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / NB) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] model_rd(input int w);
        return model.exists(w) ? model[w] : '0;
    endfunction

    function automatic void model_wr(input int w, input logic [DW-1:0] d, input logic [NB-1:0] s);
        logic [DW-1:0] cur;
        cur = model_rd(w);
        for (int i = 0; i < NB; i++) if (s[i]) cur[i*8 +: 8] = d[i*8 +: 8];
        model[w] = cur;
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are sampled 1 ns later, which
    // is what the next rising edge will see.
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                               input logic [IW-1:0] id, input bit gaps, input int bdelay,
                               input int abort_at);
        bit hs;
        int k;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awburst = burst; awid = id;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin
            #1 hs = awready;
            @(negedge clk);
        end
        awvalid = 1'b0;
        chk("aw_handshake", DW'(hs), DW'(1));
        k = 0;
        for (int t = 0; t < 2000 && k <= len && k != abort_at; t++) begin
            wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata  = wr_data_q[k];
            wstrb  = wr_strb_q[k];
            wlast  = (k == len);
            #1;
            if (wvalid && wready) begin
                model_wr(word_of(beat_addr(addr, len, burst, k)), wr_data_q[k], wr_strb_q[k]);
                k++;
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (abort_at >= 0) return;
        chk("w_beat_count", DW'(k), DW'(len + 1));
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin
            #1 hs = bvalid;
            if (!hs) @(negedge clk);
        end
        chk("b_valid", DW'(hs), DW'(1));
        for (int d = 0; d < bdelay; d++) begin
            chk("b_held", DW'(bvalid), DW'(1));
            chk("aw_blocked", DW'(awready), DW'(0));
            @(negedge clk);
            #1;
        end
        bready = 1'b1;
        chk("b_id", DW'(bid), DW'(id));
        chk("b_resp", DW'(bresp), DW'(0));
        @(negedge clk);
        bready = 1'b0;
        #1 chk("b_drop", DW'(bvalid), DW'(0));
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input logic [IW-1:0] id, input bit stall);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] held_data;
        logic          held_last;
        bit            held;
        bit            hs;
        int            k;
        for (int i = 0; i <= len; i++) exp_q.push_back(model_rd(word_of(beat_addr(addr, len, burst, i))));
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; arlen = 8'(len); arburst = burst; arid = id;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin
            #1 hs = arready;
            @(negedge clk);
        end
        arvalid = 1'b0;
        chk("ar_handshake", DW'(hs), DW'(1));
        k = 0; held = 1'b0; held_data = '0; held_last = 1'b0;
        for (int t = 0; t < 2000 && k <= len; t++) begin
            rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held) begin
                chk("r_stall_data", rdata, held_data);
                chk("r_stall_ctl", DW'({rvalid, rlast}), DW'({1'b1, held_last}));
                held = 1'b0;
            end
            if (rvalid && rready) begin
                chk("r_data", rdata, exp_q.pop_front());
                chk("r_last", DW'(rlast), DW'(k == len));
                chk("r_id_resp", DW'({rid, rresp}), DW'({id, 2'b00}));
                k++;
            end else if (rvalid) begin
                held = 1'b1; held_data = rdata; held_last = rlast;
            end
            @(negedge clk);
        end
        rready = 1'b0;
        chk("r_beat_count", DW'(k), DW'(len + 1));
        #1 chk("r_idle", DW'(rvalid), DW'(0));
    endtask

    task automatic fill(input int n, input int kind);
        wr_data_q.delete(); wr_strb_q.delete();
        for (int i = 0; i < n; i++) begin
            wr_data_q.push_back(kind == 0 ? DW'(i) : {$urandom, $urandom, $urandom, $urandom});
            wr_strb_q.push_back(kind == 0 || $urandom_range(0, 1) == 0 ? {NB{1'b1}} : NB'($urandom));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, DW'({awready, wready, bvalid, arready, rvalid, rlast,
                      bresp, rresp, bid, rid, buser, ruser}), DW'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len;
        logic [1:0] burst;
        logic [31:0] addr;

        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;

        repeat (3) @(negedge clk);
        #1 chk_idle_outputs("reset_state");
        aresetn = 1'b1;

        // 1: INCR 32 beats, data = beat index
        fill(32, 0);
        write_burst(32'h1000, 31, 2'b01, 1'b1, 1'b0, 0, -1);
        read_burst(32'h1000, 31, 2'b01, 1'b1, 1'b0);

        // 2: byte strobes merge into an existing word
        wr_data_q = '{ {DW{1'b1}} };  wr_strb_q = '{ {NB{1'b1}} };
        write_burst(32'h2000, 0, 2'b01, 1'b0, 1'b0, 0, -1);
        wr_data_q = '{ DW'(32'h11223344) };  wr_strb_q = '{ NB'(16'h000F) };
        write_burst(32'h2000, 0, 2'b01, 1'b0, 1'b0, 0, -1);
        read_burst(32'h2000, 0, 2'b01, 1'b0, 1'b0);
        chk("strb_merge_model", model_rd(word_of(32'h2000)), {{(DW-32){1'b1}}, 32'h11223344});

        // 3: WRAP len 3 starting mid-block, read back linearly
        fill(4, 1);
        write_burst(32'h1020, 3, 2'b10, 1'b1, 1'b0, 0, -1);
        read_burst(32'h1000, 3, 2'b01, 1'b1, 1'b0);

        // 4: FIXED keeps hitting one word; the neighbour stays intact
        fill(1, 1);
        write_burst(32'h3010, 0, 2'b01, 1'b0, 1'b0, 0, -1);
        fill(4, 1);
        write_burst(32'h3000, 3, 2'b00, 1'b0, 1'b0, 0, -1);
        read_burst(32'h3000, 1, 2'b01, 1'b0, 1'b0);

        // 5: delayed BREADY and throttled RREADY
        fill(8, 1);
        write_burst(32'h0400, 7, 2'b01, 1'b1, 1'b1, 5, -1);
        read_burst(32'h0400, 7, 2'b01, 1'b1, 1'b1);

        // INCR past the array top aliases back to word 0
        fill(4, 1);
        write_burst(32'h3FE0, 3, 2'b01, 1'b0, 1'b0, 0, -1);
        read_burst(32'h0000, 1, 2'b01, 1'b0, 1'b0);
        read_burst(32'h3FE0, 3, 2'b01, 1'b0, 1'b0);

        // 6: reset in the middle of a 32-beat write; beat 10 is on the reset edge
        fill(1, 1);
        write_burst(32'h08A0, 0, 2'b01, 1'b0, 1'b0, 0, -1);
        fill(32, 1);
        write_burst(32'h0800, 31, 2'b01, 1'b1, 1'b0, 0, 10);
        wvalid = 1'b1; wdata = wr_data_q[10]; wstrb = wr_strb_q[10];
        aresetn = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        #1 chk_idle_outputs("reset_mid_burst");
        aresetn = 1'b1;
        read_burst(32'h0800, 10, 2'b01, 1'b0, 1'b0);

        // random bursts, some with a concurrent read of the region from step 1
        for (int it = 0; it < 12; it++) begin
            burst = 2'($urandom_range(0, 3));
            len   = (burst == 2'b10) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
            addr  = 32'h2000 + 32'($urandom_range(0, 95) << 4);
            fill(len + 1, 1);
            if (it % 2 == 0) begin
                fork
                    write_burst(addr, len, burst, 1'($urandom), 1'($urandom), $urandom_range(0, 3), -1);
                    read_burst(32'h1000 + 32'($urandom_range(4, 15) << 4), $urandom_range(0, 15),
                               2'b01, 1'($urandom), 1'($urandom));
                join
            end else begin
                write_burst(addr, len, burst, 1'($urandom), 1'($urandom), $urandom_range(0, 3), -1);
            end
            read_burst(addr, len, burst, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
